// File: rtl/contador_crescente_bcd.sv
// Four-digit BCD up-counter with preset, external target value and an
// IDLE/RUN/PAUSE/DONE control FSM; tc pulses for one cycle on the 9999->0000 wrap.
module contador_crescente_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [15:0] limit,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] count,
    output logic        tc,
    output logic        done,
    output logic        running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] count_r;
    logic [15:0] count_s;
    logic        tc_r;
    logic        tc_s;
    logic [16:0] inc_s;

    // Forces every non-decimal nibble to zero so count never carries an invalid digit.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] value);
        logic [15:0] result;
        result = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                result[4*i +: 4] = 4'd0;
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    // Ripple BCD +1; bit 16 is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_increment(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = 16'h0000;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!carry) begin
                result[4*i +: 4] = value[4*i +: 4];
            end else if (value[4*i +: 4] >= 4'd9) begin
                result[4*i +: 4] = 4'd0;
            end else begin
                result[4*i +: 4] = value[4*i +: 4] + 4'd1;
                carry            = 1'b0;
            end
        end
        return {carry, result};
    endfunction

    assign inc_s = bcd_increment(count_r);

    // Next-state, next-count and wrap pulse; load dominates, then stop > start > tick.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        tc_s    = 1'b0;
        if (load) begin
            count_s = bcd_sanitize(data);
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stop) begin
                        state_s = ST_IDLE;
                    end else if (start) begin
                        // Already at target: finish without counting.
                        if (count_r == limit) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_s = ST_PAUSE;
                    end else if (tick) begin
                        count_s = inc_s[15:0];
                        tc_s    = inc_s[16];
                        if (inc_s[15:0] == limit) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else if (count_r == limit) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_s = ST_PAUSE;
                    end else if (start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state_s = ST_DONE;
                    end else if (start) begin
                        count_s = 16'h0000;
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    count_s = 16'h0000;
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and wrap-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 16'h0000;
            tc_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            tc_r    <= tc_s;
        end
    end

    assign count   = count_r;
    assign tc      = tc_r;
    assign done    = (state_r == ST_DONE);
    assign running = (state_r == ST_RUN);

endmodule

// File: tb/tb_contador_crescente_bcd.sv
// Directed self-checking bench for contador_crescente_bcd with hand-computed expectations.
module tb_contador_crescente_bcd;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [15:0] limit;
    logic        tick;
    logic        start;
    logic        stop;
    logic [15:0] count;
    logic        tc;
    logic        done;
    logic        running;

    int n_cmp;
    int n_err;

    contador_crescente_bcd dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data    (data),
        .limit   (limit),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .count   (count),
        .tc      (tc),
        .done    (done),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] c, input logic t,
                               input logic d, input logic r);
        check_eq({tag, ".count"}, {16'h0, count}, {16'h0, c});
        check_eq({tag, ".tc"}, {31'h0, tc}, {31'h0, t});
        check_eq({tag, ".done"}, {31'h0, done}, {31'h0, d});
        check_eq({tag, ".running"}, {31'h0, running}, {31'h0, r});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; load = 1'b0; data = 16'h0000; limit = 16'h0000;
        tick = 1'b0; start = 1'b0; stop = 1'b0;
        step(); step();
        check_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Count 1..5 up to limit 0005
        reset = 1'b0; limit = 16'h0005; start = 1'b1; tick = 1'b1;
        step();
        check_state("start", 16'h0000, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq($sformatf("cnt%0d", i), {16'h0, count}, i);
            check_eq($sformatf("done%0d", i), {31'h0, done}, (i == 5) ? 32'd1 : 32'd0);
        end
        step(); step();
        check_state("hold_done", 16'h0005, 1'b0, 1'b1, 1'b0);

        // Three-digit carry 0999 -> 1000
        tick = 1'b0; load = 1'b1; data = 16'h0999; limit = 16'h9999;
        step();
        load = 1'b0;
        check_state("load0999", 16'h0999, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check_state("carry1000", 16'h1000, 1'b0, 1'b0, 1'b1);

        // Wrap 9999 -> 0000 with one-cycle tc
        load = 1'b1; data = 16'h9999; limit = 16'h0001;
        step();
        load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_state("run9999", 16'h9999, 1'b0, 1'b0, 1'b1);
        tick = 1'b1; step(); tick = 1'b0;
        check_state("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        check_state("tc_gone", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Pause with tick held, then resume
        load = 1'b1; data = 16'h0042; limit = 16'h9999;
        step();
        load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        stop = 1'b1; tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("pause%0d", i), 16'h0042, 1'b0, 1'b0, 1'b0);
        end
        stop = 1'b0; start = 1'b1;
        step();
        check_state("resume", 16'h0042, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        step();
        tick = 1'b0;
        check_state("after_resume", 16'h0043, 1'b0, 1'b0, 1'b1);

        // Invalid digits load as zero; load while running returns to IDLE
        load = 1'b1; data = 16'hF3A7;
        step();
        load = 1'b0;
        check_state("sanitize", 16'h0307, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check_eq("run0307", {31'h0, running}, 32'd1);
        load = 1'b1; data = 16'h0123;
        step();
        load = 1'b0;
        check_state("load_in_run", 16'h0123, 1'b0, 1'b0, 1'b0);

        // Start and stop together act as stop
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_state("start_stop", 16'h0123, 1'b0, 1'b0, 1'b0);

        // count==limit at start goes straight to DONE; restart clears
        load = 1'b1; data = 16'h0010; limit = 16'h0010;
        step();
        load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_state("direct_done", 16'h0010, 1'b0, 1'b1, 1'b0);
        step();
        check_state("done_hold", 16'h0010, 1'b0, 1'b1, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check_state("restart", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Limit changed externally to match the held count
        limit = 16'h0000;
        step();
        check_state("limit_match", 16'h0000, 1'b0, 1'b1, 1'b0);

        // Reset overrides everything at 9999
        load = 1'b1; data = 16'h9999; limit = 16'h0001;
        step();
        load = 1'b0;
        start = 1'b1; step();
        reset = 1'b1; load = 1'b1; data = 16'h1234; tick = 1'b1;
        step();
        check_state("reset_prio", 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; load = 1'b0; start = 1'b0; tick = 1'b1;
        step(); step();
        check_state("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
